// File: rtl/traffic_input_conditioner.sv
// Input conditioning for the traffic controller: 2-flop sync + debounce on the
// pedestrian button and both loop detectors, ped request latch, windowed vehicle counts.
module traffic_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned WINDOW_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pedButtonRaw,
    input  logic       mainLoopRaw,
    input  logic       sideLoopRaw,
    input  logic       pedClear,
    output logic       pedButton,
    output logic [2:0] mainTrafficIn,
    output logic [2:0] sideTrafficIn,
    output logic       windowDone
);

    localparam int unsigned N_CH  = 3;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES);
    localparam int unsigned CH_PED  = 0;
    localparam int unsigned CH_MAIN = 1;
    localparam int unsigned CH_SIDE = 2;

    logic [N_CH-1:0]  raw_c;
    logic [N_CH-1:0]  s1_q, s2_q;
    logic [N_CH-1:0]  deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  rise_c;

    logic             ped_q, ped_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             win_edge_c;
    logic [2:0]       acc_main_q, acc_main_d, acc_side_q, acc_side_d;
    logic [2:0]       sum_main_c, sum_side_c;
    logic [2:0]       main_q, main_d, side_q, side_d;
    logic             done_q, done_d;

    function automatic logic [2:0] sat_inc(input logic [2:0] a, input logic inc);
        return (a == 3'd7) ? 3'd7 : a + {2'b00, inc};
    endfunction

    assign raw_c = {sideLoopRaw, mainLoopRaw, pedButtonRaw};

    // Per-channel debounce: a level flips only after DEBOUNCE_CYCLES straight disagreements.
    always_comb begin
        deb_d  = deb_q;
        rise_c = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d[i]  = s2_q[i];
                cnt_d[i]  = '0;
                rise_c[i] = s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Ped latch, window counter and saturating accumulators; set beats clear.
    always_comb begin
        ped_d      = ped_q;
        win_d      = win_q + WIN_W'(1);
        win_edge_c = (win_q == WIN_W'(WINDOW_CYCLES - 1));
        sum_main_c = sat_inc(acc_main_q, rise_c[CH_MAIN]);
        sum_side_c = sat_inc(acc_side_q, rise_c[CH_SIDE]);
        acc_main_d = sum_main_c;
        acc_side_d = sum_side_c;
        main_d     = main_q;
        side_d     = side_q;
        done_d     = 1'b0;

        if (rise_c[CH_PED]) begin
            ped_d = 1'b1;
        end else if (pedClear) begin
            ped_d = 1'b0;
        end

        if (win_edge_c) begin
            win_d      = '0;
            main_d     = sum_main_c;
            side_d     = sum_side_c;
            acc_main_d = '0;
            acc_side_d = '0;
            done_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
            ped_q      <= 1'b0;
            win_q      <= '0;
            acc_main_q <= '0;
            acc_side_q <= '0;
            main_q     <= '0;
            side_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            s1_q       <= raw_c;
            s2_q       <= s1_q;
            deb_q      <= deb_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ped_q      <= ped_d;
            win_q      <= win_d;
            acc_main_q <= acc_main_d;
            acc_side_q <= acc_side_d;
            main_q     <= main_d;
            side_q     <= side_d;
            done_q     <= done_d;
        end
    end

    assign pedButton     = ped_q;
    assign mainTrafficIn = main_q;
    assign sideTrafficIn = side_q;
    assign windowDone    = done_q;

endmodule

// File: doc/traffic_input_conditioner.md
Name: traffic_input_conditioner

Overview:
Front-end conditioning stage that directly feeds the traffic controller top level. It synchronizes and debounces the raw pedestrian push-button and the two vehicle loop detectors (main road and side road). It produces a latched pedestrian request level (pedButton) and, per road, a 3-bit saturating vehicle-arrival count sampled over a fixed window (mainTrafficIn, sideTrafficIn). These are the exact inputs the controller consumes.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized cycles of disagreement needed before a debounced level flips; legal range 1..255.
WINDOW_CYCLES, 64, length of the vehicle-count sampling window in clk cycles; legal range 2..65535.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset (reset==0 at a rising clk edge resets the block).
pedButtonRaw  input  1  asynchronous, bouncy pedestrian push-button, active high.
mainLoopRaw  input  1  asynchronous main-road loop detector, high while a vehicle is present.
sideLoopRaw  input  1  asynchronous side-road loop detector, high while a vehicle is present.
pedClear  input  1  one-cycle pulse from the controller when the pedestrian phase has been served.
pedButton  output  1  latched pedestrian request level.
mainTrafficIn  output  3  main-road arrivals in the last completed window, saturating at 7.
sideTrafficIn  output  3  side-road arrivals in the last completed window, saturating at 7.
windowDone  output  1  one-cycle pulse marking an update of mainTrafficIn and sideTrafficIn.

Behaviour:
- One clock only; every state element updates on posedge clk.
- Reset (reset==0 at an edge) clears all of the following to 0:
  - synchronizer flops, debounced levels and debounce counters;
  - pedButton, the per-road accumulators, mainTrafficIn, sideTrafficIn;
  - windowDone and the window counter.
- Reset mid-window discards any partial counts. Reset mid-debounce discards the pending transition.
- Synchronizer:
  - Each raw input passes through 2 flops (s1, s2).
  - No logic reads s1 or the raw inputs directly.
- Debounce, per channel; independent instances for ped, main and side:
  - State is deb (1 bit) plus a counter wide enough to hold DEBOUNCE_CYCLES.
  - Each edge where s2==deb: counter<=0.
  - Each edge where s2!=deb and counter==DEBOUNCE_CYCLES-1: deb<=s2, counter<=0, and a rise event is raised for this edge when s2==1.
  - Otherwise, when s2!=deb: counter<=counter+1.
  - Pulses or gaps shorter than DEBOUNCE_CYCLES synchronized cycles are fully rejected.
- Latency: raw held high from before edge k gives deb=1 (and the rise event) at edge k+1+DEBOUNCE_CYCLES.
- Pedestrian latch:
  - pedButton<=1 on a ped rise event; pedButton<=0 on pedClear.
  - If both occur at the same edge, set wins, so a fresh press is never lost.
  - Holding the button does not re-trigger; only a debounced 0->1 transition sets the latch.
- Window counter:
  - Counts 0..WINDOW_CYCLES-1 and wraps to 0.
  - The edge where the counter==WINDOW_CYCLES-1 is the "window edge".
- Accumulators (3-bit, per road), on a non-window edge:
  - acc<=min(acc+rise,7).
  - Saturation holds at 7 and never wraps to 0.
- On the window edge:
  - TrafficIn<=min(acc+rise,7), so a rise event on that same edge is counted in the closing window.
  - acc<=0 and windowDone<=1.
- windowDone is 0 on every other edge. Outputs are registered and hold steady between window edges.
- First outputs appear WINDOW_CYCLES edges after reset release. Before that, TrafficIn is 0.
- Main and side channels are fully independent. Simultaneous rises on both roads increment both.

Test Plan:
1. Reset: drive reset=0 for 3 edges with all raw inputs at 1. Required: all outputs 0 during reset and at the first edge after release; windowDone=0.
2. Debounce latency and glitch rejection (D=4): pedButtonRaw high from before edge k. Required: pedButton=1 after edge k+5. Separately, a 3-cycle raw pulse must leave pedButton at 0.
3. Ped latch: press, then assert pedClear while still pressed. Required: pedButton=0 and it stays 0 until a release plus a re-press is debounced. pedClear on the same edge as a rise event leaves pedButton=1.
4. Counting (D=2, W=32): 3 clean main pulses and 1 side pulse inside one window. Required: at the window edge, windowDone=1 for exactly one cycle, mainTrafficIn=3 and sideTrafficIn=1. The next window with no pulses must give 0 and 0.
5. Saturation and boundary (D=1, W=64): 10 main pulses in one window, with the last rise landing exactly on the window edge. Required: mainTrafficIn=7. The following window starts from 0; a single pulse there gives 1, not 8.
6. Reset mid-window: 2 main pulses, then reset=0 for 1 edge at window count 20. Required: windowDone and outputs are 0, and the next window edge occurs WINDOW_CYCLES edges after release with mainTrafficIn=0.
